// File: rtl/banner_scroller_if.sv
// rtl/banner_scroller_if.sv - row handshake bundle between banner_scroller and the LED row driver
// Modports:
//   master : drives row_valid, row_index, row_pixels; samples row_ready
//   slave  : samples row_valid, row_index, row_pixels; drives row_ready
interface banner_scroller_if #(
    parameter int WIN = 16
);
    logic           row_valid;
    logic           row_ready;
    logic [3:0]     row_index;
    logic [WIN-1:0] row_pixels;

    modport master (
        output row_valid,
        output row_index,
        output row_pixels,
        input  row_ready
    );

    modport slave (
        input  row_valid,
        input  row_index,
        input  row_pixels,
        output row_ready
    );
endinterface

// File: rtl/banner_scroller.sv
// rtl/banner_scroller.sv - banner ROM row reader with horizontal scroll window
// Optional feature macro: BANNER_SCROLL_EN (defined = scrolling; undefined = offset fixed at 0)
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_enable       : frames run continuously while high
//   o_rom_addr     : ROM row address (ROM registers it, data returns next cycle)
//   i_rom_data     : ROM word, column 0 in the MSB
//   o_frame_done   : one-cycle pulse after the last row of a frame is accepted
//   o_offset       : current scroll offset, 0..WIDTH-1
//   row_bus        : row_valid/row_ready handshake carrying row_index and row_pixels
module banner_scroller #(
    parameter int ROWS      = 15,
    parameter int WIDTH     = 71,
    parameter int WIN       = 16,
    parameter int FRAME_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    output logic [4:0]        o_rom_addr,
    input  logic [WIDTH-1:0]  i_rom_data,
    output logic              o_frame_done,
    output logic [6:0]        o_offset,
    banner_scroller_if.master row_bus
);

    if (FRAME_DIV < 1) begin : g_frame_div_check
        $error("banner_scroller: FRAME_DIV must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_FETCH,
        S_PRESENT
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_row;
    logic [WIN-1:0]       r_pixels;
    logic                 r_frame_done;
    logic                 w_row_valid;
    logic                 w_accept;
    logic                 w_last_row;
    logic                 w_frame_end;
    logic [6:0]           w_offset;
    logic [2*WIDTH-1:0]   w_dbl_word;
    logic [7:0]           w_shift;
    logic [WIN-1:0]       w_window;

    assign w_accept    = (r_state == S_PRESENT) && row_bus.row_ready;
    assign w_last_row  = (r_row == 4'(ROWS - 1));
    assign w_frame_end = w_accept && w_last_row;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake output; enable is only consulted in IDLE and
    // at the end of a frame, so a frame in flight always runs to completion.
    always_comb begin
        w_state_next = r_state;
        w_row_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_state_next = S_PRESENT;
            end
            S_PRESENT: begin
                w_row_valid = 1'b1;
                if (row_bus.row_ready) begin
                    if (w_last_row && !i_enable) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_ADDR;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Row counter doubles as the ROM address, so it only moves on acceptance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row        <= '0;
            r_pixels     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_accept) begin
                r_row <= w_last_row ? 4'd0 : r_row + 4'd1;
            end
            if (r_state == S_FETCH) begin
                r_pixels <= w_window;
            end
        end
    end

`ifdef BANNER_SCROLL_EN
    localparam int FCW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [FCW-1:0] r_frame_cnt;
    logic [6:0]     r_offset;

    // Offset moves in the same edge that raises frame_done, so the whole of
    // the next frame sees the new value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_cnt <= '0;
            r_offset    <= '0;
        end else if (w_frame_end) begin
            if (r_frame_cnt == FCW'(FRAME_DIV - 1)) begin
                r_frame_cnt <= '0;
                r_offset    <= (r_offset == 7'(WIDTH - 1)) ? 7'd0 : r_offset + 7'd1;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_offset = r_offset;
`else
    assign w_offset = '0;
`endif

    // Two copies of the word back to back make the wrap past column WIDTH-1
    // a plain right shift: column c sits at bit 2*WIDTH-1-c, so the window
    // whose MSB is column offset starts WIN bits above bit 2*WIDTH-WIN-offset.
    assign w_dbl_word = {i_rom_data, i_rom_data};
    assign w_shift    = 8'(2 * WIDTH - WIN) - {1'b0, w_offset};
    assign w_window   = WIN'(w_dbl_word >> w_shift);

    assign o_rom_addr         = {1'b0, r_row};
    assign o_frame_done       = r_frame_done;
    assign o_offset           = w_offset;
    assign row_bus.row_valid  = w_row_valid;
    assign row_bus.row_index  = r_row;
    assign row_bus.row_pixels = r_pixels;

endmodule

// File: tb/tb_banner_scroller.sv
// tb/tb_banner_scroller.sv - self-checking bench for banner_scroller
module tb_banner_scroller;
    localparam int ROWS      = 15;
    localparam int WIDTH     = 71;
    localparam int WIN       = 16;
    localparam int FRAME_DIV = 2;
`ifdef BANNER_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             enable = 1'b0;
    logic [4:0]       rom_addr;
    logic [WIDTH-1:0] rom_data = '0;
    logic             frame_done;
    logic [6:0]       offset;
    logic [WIDTH-1:0] rom_mem [ROWS];

    int n_vec = 0;
    int n_err = 0;

    banner_scroller_if #(.WIN(WIN)) bus ();

    banner_scroller #(
        .ROWS(ROWS), .WIDTH(WIDTH), .WIN(WIN), .FRAME_DIV(FRAME_DIV)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (enable),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .o_frame_done(frame_done),
        .o_offset    (offset),
        .row_bus     (bus)
    );

    always #5 clk = ~clk;

    // ROM model with registered address
    always @(posedge clk) begin
        if (rom_addr < 5'(ROWS)) rom_data <= rom_mem[rom_addr];
        else                     rom_data <= '0;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference: window straight from the column/offset definition
    function automatic logic [WIN-1:0] win_of(input logic [WIDTH-1:0] w, input int off);
        logic [WIN-1:0] r;
        r = '0;
        for (int k = 0; k < WIN; k++) r[WIN-1-k] = w[WIDTH-1-((off + k) % WIDTH)];
        return r;
    endfunction

    function automatic int model_offset(input int frames);
        return SCROLL ? (frames / FRAME_DIV) % WIDTH : 0;
    endfunction

    // Scoreboard: rows in order, frame_done/offset timing, stability under stall
    int             m_row      = 0;
    int             m_frames   = 0;
    bit             m_fd       = 1'b0;
    bit             m_stall    = 1'b0;
    bit             m_rst_seen = 1'b1;
    logic [3:0]     m_idx;
    logic [WIN-1:0] m_pix;

    always @(negedge clk) begin
        if (rst) begin
            m_row = 0; m_frames = 0; m_fd = 1'b0; m_stall = 1'b0; m_rst_seen = 1'b1;
        end else begin
            if (m_rst_seen) begin
                check("rst_valid", bus.row_valid, 1'b0);
                check("rst_index", bus.row_index, 4'd0);
                check("rst_pixels", bus.row_pixels, '0);
                m_rst_seen = 1'b0;
            end
            check("mon_frame_done", frame_done, m_fd);
            check("mon_offset", offset, model_offset(m_frames));
            check("mon_rom_addr", rom_addr, m_row);
            if (m_stall) begin
                check("stall_valid", bus.row_valid, 1'b1);
                check("stall_index", bus.row_index, m_idx);
                check("stall_pixels", bus.row_pixels, m_pix);
            end
            if (bus.row_valid === 1'b1) begin
                check("mon_index", bus.row_index, m_row);
                check("mon_pixels", bus.row_pixels, win_of(rom_mem[m_row], model_offset(m_frames)));
            end
            m_stall = (bus.row_valid === 1'b1) && !bus.row_ready;
            m_idx   = bus.row_index;
            m_pix   = bus.row_pixels;
            m_fd    = 1'b0;
            if (bus.row_valid === 1'b1 && bus.row_ready) begin
                if (m_row == ROWS - 1) begin
                    m_row = 0; m_frames++; m_fd = 1'b1;
                end else begin
                    m_row++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_onehot();
        for (int r = 0; r < ROWS; r++) begin
            rom_mem[r] = '0;
            rom_mem[r][WIDTH-1-r] = 1'b1;
        end
    endtask

    task automatic wait_row(input int row, input int limit, input string name);
        int n = 0;
        while (!(bus.row_valid === 1'b1 && bus.row_index == 4'(row)) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) timeout(name);
    endtask

    task automatic wait_fd(input int limit, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (frame_done !== 1'b1 && n < limit);
        if (frame_done !== 1'b1) timeout(name);
    endtask

    typedef struct {
        int         cyc;
        logic       v;
        logic [3:0] idx;
        logic [15:0] pix;
        logic [4:0] addr;
        logic       fd;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int n;
        int nframes;

        tbl[0]  = '{1,  1'b0, 4'd0,  16'h0000, 5'd0,  1'b0};
        tbl[1]  = '{2,  1'b0, 4'd0,  16'h0000, 5'd0,  1'b0};
        tbl[2]  = '{3,  1'b1, 4'd0,  16'h8000, 5'd0,  1'b0};
        tbl[3]  = '{4,  1'b0, 4'd0,  16'h0000, 5'd1,  1'b0};
        tbl[4]  = '{6,  1'b1, 4'd1,  16'h4000, 5'd1,  1'b0};
        tbl[5]  = '{9,  1'b1, 4'd2,  16'h2000, 5'd2,  1'b0};
        tbl[6]  = '{18, 1'b1, 4'd5,  16'h0400, 5'd5,  1'b0};
        tbl[7]  = '{44, 1'b0, 4'd0,  16'h0000, 5'd14, 1'b0};
        tbl[8]  = '{45, 1'b1, 4'd14, 16'h0002, 5'd14, 1'b0};
        tbl[9]  = '{46, 1'b0, 4'd0,  16'h0000, 5'd0,  1'b1};
        tbl[10] = '{47, 1'b0, 4'd0,  16'h0000, 5'd0,  1'b0};
        tbl[11] = '{48, 1'b1, 4'd0,  16'h8000, 5'd0,  1'b0};

        // First frame, cycle-exact, from reset release
        load_onehot();
        enable = 1'b1;
        bus.row_ready = 1'b1;
        do_reset();
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            while (cyc < tbl[i].cyc) begin
                tick();
                cyc++;
            end
            check($sformatf("tbl%0d_valid", i), bus.row_valid, tbl[i].v);
            check($sformatf("tbl%0d_addr", i), rom_addr, tbl[i].addr);
            check($sformatf("tbl%0d_frame_done", i), frame_done, tbl[i].fd);
            if (tbl[i].v) begin
                check($sformatf("tbl%0d_index", i), bus.row_index, tbl[i].idx);
                check($sformatf("tbl%0d_pixels", i), bus.row_pixels, tbl[i].pix);
            end
        end

        // Backpressure on row 5
        do_reset();
        wait_row(5, 100, "bp_wait_row5");
        bus.row_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", bus.row_valid, 1'b1);
            check("bp_index", bus.row_index, 4'd5);
            check("bp_pixels", bus.row_pixels, 16'h0400);
            check("bp_addr", rom_addr, 5'd5);
        end
        bus.row_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.row_valid === 1'b1 && bus.row_index == 4'd6) && n < 20);
        check("bp_row6_latency", n, 3);
        check("bp_row6_pixels", bus.row_pixels, 16'h0200);

        // Scroll steps every FRAME_DIV frames
        do_reset();
        wait_fd(100, "scroll_fd1");
        check("scroll_offset_fd1", offset, 7'd0);
        wait_fd(100, "scroll_fd2");
        check("scroll_offset_fd2", offset, SCROLL ? 7'd1 : 7'd0);
        wait_row(0, 10, "scroll_f3_row0");
        check("scroll_f3_row0", bus.row_pixels, SCROLL ? 16'h0000 : 16'h8000);
        wait_row(1, 10, "scroll_f3_row1");
        check("scroll_f3_row1", bus.row_pixels, SCROLL ? 16'h8000 : 16'h4000);

        // Long run: offset 65 with scrolling, 10 static frames without
        nframes = SCROLL ? 130 : 10;
        for (int f = 2; f < nframes; f++) wait_fd(100, "long_fd");
        check("long_offset", offset, SCROLL ? 7'd65 : 7'd0);
        wait_row(0, 10, "long_row0");
        check("long_row0", bus.row_pixels, SCROLL ? 16'h0200 : 16'h8000);
        wait_row(3, 20, "long_row3");
        check("long_row3", bus.row_pixels, SCROLL ? 16'h0040 : 16'h1000);
        wait_row(14, 40, "long_row14");
        check("long_row14", bus.row_pixels, SCROLL ? 16'h0000 : 16'h0002);

        // Reset while row 7 is presented
        wait_row(7, 100, "rst_wait_row7");
        bus.row_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.row_ready = 1'b1;
        check("midrst_valid", bus.row_valid, 1'b0);
        check("midrst_offset", offset, 7'd0);
        check("midrst_addr", rom_addr, 5'd0);
        check("midrst_frame_done", frame_done, 1'b0);
        tick();
        check("midrst_c1_valid", bus.row_valid, 1'b0);
        tick();
        check("midrst_c2_valid", bus.row_valid, 1'b0);
        tick();
        check("midrst_c3_valid", bus.row_valid, 1'b1);
        check("midrst_c3_index", bus.row_index, 4'd0);
        check("midrst_c3_pixels", bus.row_pixels, 16'h8000);

        // Enable dropped mid-frame: frame completes, then idle
        wait_row(4, 30, "en_wait_row4");
        enable = 1'b0;
        wait_fd(100, "en_fd");
        check("en_fd_addr", rom_addr, 5'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("en_idle_valid", bus.row_valid, 1'b0);
        end

        // Randomized traffic against the scoreboard
        for (int r = 0; r < ROWS; r++) rom_mem[r] = WIDTH'({$urandom(), $urandom(), $urandom()});
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bus.row_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            tick();
        end
        enable = 1'b0;
        bus.row_ready = 1'b1;
        for (int i = 0; i < 60; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/banner_scroller.md
# banner_scroller

Row reader and horizontal scroller for the banner ROMs. It sweeps the ROM row address and absorbs the ROM's one-cycle registered-address latency. Each row is reduced to a WIN-column window starting at a scroll offset, and the window is handed to the LED-matrix driver over a valid/ready handshake. It sits between any bannerwordN ROM (upstream) and the row driver (downstream).

## Interface
- ROWS, 15: rows per banner (ROM addresses 0..ROWS-1)
- WIDTH, 71: columns per ROM word
- WIN, 16: visible columns per output row
- FRAME_DIV, 4: complete frames per scroll step (≥1)
- clk  input  1  clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- enable  input  1  level; frames run continuously while high
- rom_addr  output  5  ROM row address (ROM registers it internally)
- rom_data  input  WIDTH  ROM word, valid the cycle after rom_addr is driven
- row_valid  output  1  row_pixels/row_index valid
- row_ready  input  1  driver accepts row
- row_index  output  4  row number of presented row
- row_pixels  output  WIN  window; MSB = leftmost visible column
- frame_done  output  1  one-cycle pulse after last row of a frame accepted
- offset  output  7  current scroll offset, 0..WIDTH-1

## Operation
- Column c (0 = leftmost) of a ROM word = bit WIDTH-1-c.
- row_pixels[WIN-1-k] = column (offset+k) mod WIDTH, for k = 0..WIN-1; the window wraps past column WIDTH-1 to column 0.
- FSM states:
  - IDLE → ADDR when enable=1.
  - ADDR: rom_addr = row counter. → FETCH.
  - FETCH: rom_data valid; window captured into row_pixels register at cycle end. → PRESENT.
  - PRESENT: row_valid=1. Stays while row_ready=0.
  - On valid&&ready, row < ROWS-1: row++, → ADDR.
  - On valid&&ready, row = ROWS-1: row←0, frame_done pulses next cycle, frame counter++. → ADDR if enable, else IDLE.
- Scroll: when the frame counter reaches FRAME_DIV-1 at frame end, it clears and offset advances by 1. offset = WIDTH-1 wraps to 0.
- offset changes only at frame boundaries; all rows of one frame use the same offset.
- enable deasserted mid-frame: the current frame completes, then the FSM enters IDLE. No partial frames.
- rom_addr always equals the row counter.

## Timing
- Reset values:
  - rom_addr 0, row_valid 0, row_index 0, row_pixels 0, frame_done 0, offset 0.
  - FSM in IDLE; row and frame counters 0.
- Reset mid-operation: the next cycle shows reset values. Any pending row is dropped.
- Latency:
  - enable high sampled in IDLE → ADDR next cycle → row_valid 2 cycles later.
  - With row_ready=1: 3 cycles per row, 45 cycles per frame (ROWS=15).
- row_pixels and row_index are stable while row_valid=1 and row_ready=0. rom_addr does not advance under backpressure.
- row_valid deasserts the cycle after acceptance (ADDR/FETCH gap).
- frame_done coincides with ADDR of row 0 of the next frame, or with IDLE.
- An offset update is visible in the same cycle as frame_done.

## Configuration
- BANNER_SCROLL_EN defined: scrolling as described.
- BANNER_SCROLL_EN undefined:
  - frame counter and offset logic removed; offset tied to 0.
  - row_pixels always shows columns 0..WIN-1.
  - frame_done still pulses.

## Test plan
Bench ROM model registers its address; row r has only column r set.
- Reset, enable=1, row_ready=1 → row_valid first high 3 cycles after reset release (IDLE→ADDR→FETCH→PRESENT). Rows 0..14 presented 3 cycles apart. Row 0 has row_pixels=16'h8000. frame_done pulses once, 45 cycles after the first ADDR.
- Hold row_ready=0 for 10 cycles on row 5 → row_valid stays 1, row_index=5 and row_pixels=16'h0400 stay stable, rom_addr=5 throughout. Row 6 appears 3 cycles after release.
- FRAME_DIV=2, run 2 frames → offset=1 coincident with the second frame_done. In frame 3, row 1 gives row_pixels=16'h8000 and row 0 gives 16'h0000.
- Force offset to 65 (run 130 frames at FRAME_DIV=2). Row 0 (column 0) → row_pixels=16'h0200 (k=6). Row 14 → 16'h0000.
- Assert rst for one cycle while row 7 is presented → next cycle: row_valid=0, offset=0, rom_addr=0, FSM IDLE. With enable held, the frame restarts at row 0.
- BANNER_SCROLL_EN undefined, 10 frames → offset=0 throughout. Row 3 always gives 16'h1000.
